puf_challenge_sequencer: RTL and testbench

//  Sequences the arbiter-PUF delay chain to produce a multi-bit response word.
//  - Expands one seed challenge into RESP_BITS challenges with an LFSR.
//  - Fires VOTES launch pulses per challenge and samples the synchronised response after each.
//  - Majority-votes each bit and assembles the word, with a valid/ready handshake to the host.
//  - Sits between the host/config logic and the PUF core; it is the PUF core's only driver of challenge and pulse.

---
 rtl/puf_challenge_sequencer_pkg.sv | 20 ++
 rtl/puf_challenge_sequencer_if.sv | 29 ++
 rtl/puf_challenge_sequencer_lfsr.sv | 41 ++++
 rtl/puf_challenge_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared definitions for the PUF challenge sequencer.
// Holds the FSM state encoding, the Galois LFSR tap constant, and the
// value that replaces an all-zero seed.
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_FIRE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, Galois right-shift form
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  // an all-zero LFSR would lock up, so a zero seed is replaced by this
  localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Host-side bus of the PUF challenge sequencer.
//   master : host / config logic (drives start, seed, abort, resp_ready)
//   slave  : sequencer (drives busy, resp_word, resp_valid, unstable_cnt)
interface puf_challenge_sequencer_if #(
  parameter int CHAL_W    = 8,
  parameter int RESP_BITS = 8,
  parameter int CNT_W     = $clog2(RESP_BITS + 1)
) ();

  logic                 start;
  logic [CHAL_W-1:0]    seed;
  logic                 abort;
  logic                 busy;
  logic [RESP_BITS-1:0] resp_word;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [CNT_W-1:0]     unstable_cnt;

  modport master (
    output start, seed, abort, resp_ready,
    input  busy, resp_word, resp_valid, unstable_cnt
  );

  modport slave (
    input  start, seed, abort, resp_ready,
    output busy, resp_word, resp_valid, unstable_cnt
  );

endinterface

// File: rtl/puf_challenge_sequencer_lfsr.sv
// Challenge-expansion LFSR.
//   clk, rst_n : clock and async active-low reset (state clears to 0)
//   load       : capture load_val (zero replaced by ZERO_SEED_SUB)
//   load_val   : seed challenge
//   advance    : step once, Galois right shift
//   state      : current LFSR state (registered)
module puf_lfsr
  import puf_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         advance,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);
  localparam logic [W-1:0] SUB  = W'(ZERO_SEED_SUB);

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == '0) ? SUB : load_val;
    end else if (advance) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer.
// Expands a seed into RESP_BITS challenges, fires VOTES launches per
// challenge, majority-votes the synchronised response and returns the word
// to the host with a valid/ready handshake.
//   clk, rst_n    : clock, async active-low reset
//   host          : host bus (slave side), see puf_challenge_sequencer_if
//   puf_challenge : challenge to the PUF mux chain
//   puf_pulse     : launch pulse into the PUF chain
//   puf_response  : arbiter output, asynchronous to clk
//
//   state  | meaning
//   IDLE   | waiting for start
//   SETUP  | challenge stable, pulse low (1 cycle)
//   FIRE   | pulse high for PULSE_CYC cycles
//   SETTLE | pulse low for SETTLE_CYC cycles, arbiter resolves
//   SAMPLE | count synchronised response, vote / advance bit
//   DONE   | word presented until resp_ready
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W      = 8,
  parameter int RESP_BITS   = 8,
  parameter int VOTES       = 5,
  parameter int PULSE_CYC   = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  puf_challenge_sequencer_if.slave  host,
  output logic [CHAL_W-1:0]         puf_challenge,
  output logic                      puf_pulse,
  input  logic                      puf_response
);

  localparam int CW = $clog2(RESP_BITS + 1);
  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TW = $clog2(((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC) + 1);

  localparam logic [VW-1:0] VOTES_M1  = VW'(VOTES - 1);
  localparam logic [VW-1:0] VOTES_ALL = VW'(VOTES);
  localparam logic [VW-1:0] VOTES_HALF = VW'(VOTES / 2);
  localparam logic [BW-1:0] LAST_BIT  = BW'(RESP_BITS - 1);
  localparam logic [TW-1:0] PULSE_M1  = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] SETTLE_M1 = TW'(SETTLE_CYC - 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [VW-1:0]        vote_q, vote_d;
  logic [VW-1:0]        ones_q, ones_d;
  logic [VW-1:0]        ones_sum;
  logic [BW-1:0]        bit_q, bit_d;
  logic [RESP_BITS-1:0] word_q, word_d;
  logic [CW-1:0]        unst_q, unst_d;
  logic                 busy_q, busy_d;
  logic                 pulse_q, pulse_d;
  logic                 valid_q, valid_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                 lfsr_load, lfsr_adv;

  puf_lfsr #(.W(CHAL_W)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (host.seed),
    .advance  (lfsr_adv),
    .state    (puf_challenge)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    vote_d    = vote_q;
    ones_d    = ones_q;
    bit_d     = bit_q;
    word_d    = word_q;
    unst_d    = unst_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    sync_d    = {sync_q[SYNC_STAGES-2:0], puf_response};
    ones_sum  = ones_q + VW'(sync_q[SYNC_STAGES-1]);

    if (host.abort) begin
      state_d = ST_IDLE;
      vote_d  = '0;
      ones_d  = '0;
      bit_d   = '0;
      word_d  = '0;
      unst_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (host.start) begin
            lfsr_load = 1'b1;
            state_d   = ST_SETUP;
            vote_d    = '0;
            ones_d    = '0;
            bit_d     = '0;
            word_d    = '0;
            unst_d    = '0;
          end
        end
        ST_SETUP: begin
          state_d = ST_FIRE;
          tmr_d   = PULSE_M1;
        end
        ST_FIRE: begin
          if (tmr_q == '0) begin
            state_d = ST_SETTLE;
            tmr_d   = SETTLE_M1;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_SETTLE: begin
          if (tmr_q == '0) state_d = ST_SAMPLE;
          else             tmr_d   = tmr_q - TW'(1);
        end
        ST_SAMPLE: begin
          state_d = ST_SETUP;
          if (vote_q != VOTES_M1) begin
            vote_d = vote_q + VW'(1);
            ones_d = ones_sum;
          end else begin
            word_d[bit_q] = (ones_sum > VOTES_HALF);
            if (ones_sum != '0 && ones_sum != VOTES_ALL) unst_d = unst_q + CW'(1);
            vote_d   = '0;
            ones_d   = '0;
            lfsr_adv = 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d = ST_DONE;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        ST_DONE: begin
          if (valid_q && host.resp_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d  = (state_d == ST_SETUP) || (state_d == ST_FIRE) ||
              (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    pulse_d = (state_d == ST_FIRE);
    // valid rises one cycle after DONE is entered and drops on handshake
    valid_d = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      unst_q  <= '0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      unst_q  <= unst_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
    end
  end

  assign puf_pulse         = pulse_q;
  assign host.busy         = busy_q;
  assign host.resp_valid   = valid_q;
  assign host.resp_word    = word_q;
  assign host.unstable_cnt = unst_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;

  localparam int CHAL_W      = 8;
  localparam int RESP_BITS   = 8;
  localparam int VOTES       = 5;
  localparam int PULSE_CYC   = 2;
  localparam int SETTLE_CYC  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LAT = 1 + RESP_BITS * VOTES * (PULSE_CYC + SETTLE_CYC + 2);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              puf_response = 1'b0;
  logic              puf_pulse;
  logic [CHAL_W-1:0] puf_challenge;

  puf_challenge_sequencer_if #(.CHAL_W(CHAL_W), .RESP_BITS(RESP_BITS)) host_if ();

  puf_challenge_sequencer #(
    .CHAL_W(CHAL_W), .RESP_BITS(RESP_BITS), .VOTES(VOTES),
    .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (host_if.slave),
    .puf_challenge (puf_challenge),
    .puf_pulse     (puf_pulse),
    .puf_response  (puf_response)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- PUF behavioural model ----------------
  logic [VOTES-1:0]  inv_mask = '0;
  int                pulse_idx = 0;
  int                pend_cnt = -1;
  logic              pend_val = 1'b0;
  logic              pulse_prev = 1'b0;
  logic [CHAL_W-1:0] chal_log[$];

  always @(posedge clk) begin
    #1;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) puf_response = pend_val;
    end
    if (puf_pulse && !pulse_prev) begin
      chal_log.push_back(puf_challenge);
      pend_val  = (^puf_challenge) ^ inv_mask[pulse_idx];
      pend_cnt  = SETTLE_CYC - 1;
      pulse_idx = (pulse_idx + 1) % VOTES;
    end
    pulse_prev = puf_pulse;
  end

  // ---------------- reference model ----------------
  logic [CHAL_W-1:0]    exp_chal[RESP_BITS];
  logic [RESP_BITS-1:0] exp_word;
  int                   exp_unst;

  task automatic model(input logic [CHAL_W-1:0] seed, input logic [VOTES-1:0] inv);
    logic [CHAL_W-1:0] s;
    int ones;
    s = (seed == 0) ? 8'h01 : seed;
    exp_word = '0;
    exp_unst = 0;
    for (int i = 0; i < RESP_BITS; i++) begin
      exp_chal[i] = s;
      ones = 0;
      for (int v = 0; v < VOTES; v++) ones += int'((^s) ^ inv[v]);
      exp_word[i] = (ones > VOTES / 2);
      if (ones != 0 && ones != VOTES) exp_unst++;
      s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_only(input logic [CHAL_W-1:0] seed, input logic [VOTES-1:0] inv);
    model(seed, inv);
    inv_mask  = inv;
    pulse_idx = 0;
    chal_log.delete();
    @(negedge clk);
    host_if.seed  = seed;
    host_if.start = 1'b1;
    @(posedge clk);
    #1 host_if.start = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic [CHAL_W-1:0] seed,
                         input logic [VOTES-1:0] inv, input bit do_ack);
    int n;
    int busy_low;
    int bad;
    start_only(seed, inv);
    check({tag, "_busy_start"}, 32'(host_if.busy), 32'd1);
    n = 0;
    busy_low = 0;
    while (!host_if.resp_valid && n < LAT + 50) begin
      @(posedge clk);
      #1;
      n++;
      if (n < LAT - 1 && !host_if.busy) busy_low++;
    end
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check({tag, "_busy_seq"}, 32'(busy_low), 32'd0);
    check({tag, "_busy_done"}, 32'(host_if.busy), 32'd0);
    check({tag, "_word"}, 32'(host_if.resp_word), 32'(exp_word));
    check({tag, "_unstable"}, 32'(host_if.unstable_cnt), 32'(exp_unst));
    check({tag, "_launches"}, 32'(chal_log.size()), 32'(RESP_BITS * VOTES));
    bad = 0;
    foreach (chal_log[i]) if (i < RESP_BITS * VOTES && chal_log[i] !== exp_chal[i / VOTES]) bad++;
    check({tag, "_challenges"}, 32'(bad), 32'd0);
    if (do_ack) begin
      @(negedge clk);
      host_if.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, 32'(host_if.resp_valid), 32'd0);
      host_if.resp_ready = 1'b0;
    end
  endtask

  task automatic wait_launches(input string tag, input int cnt);
    int n;
    n = 0;
    while (chal_log.size() < cnt && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_reach"}, 32'(chal_log.size() >= cnt), 32'd1);
  endtask

  initial begin
    int held_bad;
    int stray;
    host_if.start      = 1'b0;
    host_if.seed       = '0;
    host_if.abort      = 1'b0;
    host_if.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse", 32'(puf_pulse), 32'd0);
    check("rst_chal", 32'(puf_challenge), 32'd0);
    check("rst_busy", 32'(host_if.busy), 32'd0);
    check("rst_valid", 32'(host_if.resp_valid), 32'd0);
    check("rst_word", 32'(host_if.resp_word), 32'd0);
    check("rst_unst", 32'(host_if.unstable_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ideal PUF
    run_req("s1", 8'hA5, 5'b00000, 1'b1);
    check("s1_unst_zero", 32'(host_if.unstable_cnt), 32'd0);

    // 2: zero seed substitution
    run_req("s2", 8'h00, 5'b00000, 1'b1);
    check("s2_chal0", 32'(chal_log[0]), 32'h01);
    check("s2_chal1", 32'(chal_log[VOTES]), 32'hB8);

    // 3: votes 1 and 3 inverted -> unchanged word; 3 of 5 inverted -> flipped
    run_req("s3a", 8'hA5, 5'b01010, 1'b1);
    check("s3a_unst8", 32'(host_if.unstable_cnt), 32'd8);
    run_req("s3b", 8'hA5, 5'b01011, 1'b1);
    check("s3b_unst8", 32'(host_if.unstable_cnt), 32'd8);

    // 4: hold in DONE with ready low; start pulses ignored
    run_req("s4", 8'h3C, 5'b00100, 1'b0);
    held_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      host_if.start = c[0];
      host_if.seed  = 8'(c * 37);
      @(posedge clk);
      #1;
      if (host_if.resp_valid !== 1'b1 || host_if.resp_word !== exp_word ||
          host_if.unstable_cnt !== 4'(exp_unst) || host_if.busy !== 1'b0) held_bad++;
    end
    check("s4_held", 32'(held_bad), 32'd0);
    @(negedge clk);
    host_if.start = 1'b0;
    host_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    host_if.resp_ready = 1'b0;
    check("s4_valid_drop", 32'(host_if.resp_valid), 32'd0);
    check("s4_word_kept", 32'(host_if.resp_word), 32'(exp_word));
    @(posedge clk);
    #1;
    check("s4_idle_busy", 32'(host_if.busy), 32'd0);

    // 5: abort during bit 3 FIRE
    start_only(8'h5A, 5'b00000);
    wait_launches("s5", 3 * VOTES + 1);
    check("s5_in_fire", 32'(puf_pulse), 32'd1);
    check("s5_bit3_chal", 32'(puf_challenge), 32'(exp_chal[3]));
    host_if.abort = 1'b1;
    @(posedge clk);
    #1;
    host_if.abort = 1'b0;
    check("s5_pulse", 32'(puf_pulse), 32'd0);
    check("s5_busy", 32'(host_if.busy), 32'd0);
    check("s5_valid", 32'(host_if.resp_valid), 32'd0);
    stray = 0;
    for (int c = 0; c < LAT + 20; c++) begin
      @(posedge clk);
      #1;
      if (host_if.resp_valid || host_if.busy || puf_pulse) stray++;
    end
    check("s5_quiet", 32'(stray), 32'd0);
    run_req("s5_new", 8'(8'h11 + $urandom_range(0, 200)), 5'(($urandom_range(0, 31))), 1'b1);

    // 6: async reset mid-SETTLE
    start_only(8'hC3, 5'b00000);
    wait_launches("s6", VOTES + 1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_pulse", 32'(puf_pulse), 32'd0);
    check("s6_chal", 32'(puf_challenge), 32'd0);
    check("s6_busy", 32'(host_if.busy), 32'd0);
    check("s6_valid", 32'(host_if.resp_valid), 32'd0);
    check("s6_word", 32'(host_if.resp_word), 32'd0);
    check("s6_unst", 32'(host_if.unstable_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("s6_after", 8'hC3, 5'b00000, 1'b1);

    // randomized seeds and vote corruption patterns
    for (int r = 0; r < 5; r++) begin
      run_req($sformatf("rnd%0d", r), 8'($urandom), 5'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
